// File: rtl/quad_nibble_pkg.sv
// Shared types and constants for the QUAD.nibble CPU.
// The program memory reset image lives here so the core and memory agree on boot contents.
package quad_nibble_pkg;

  typedef logic [15:0] word_t;
  typedef logic [3:0]  paddr_t;

  localparam int PROGMEM_DEPTH = 16;

  typedef word_t [PROGMEM_DEPTH-1:0] progmem_image_t;

  // Boot image: all NOPs until a program is baked in here.
  localparam progmem_image_t PROGMEM_RESET_IMAGE = '{default: 16'h0000};

endpackage

// File: rtl/prog_mem.sv
// Single-port program memory: flop array loaded from the package reset image,
// synchronous write, one-cycle registered read with write-first collision behaviour.
module prog_mem
  import quad_nibble_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = PROGMEM_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              write_en,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = (32'(addr) < DEPTH);

  // Flops rather than RAM so the whole array can snap back to the image asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(PROGMEM_RESET_IMAGE[i]);
      end
    end else if (write_en && in_range) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
    end else if (!in_range) begin
      dout <= '0;
    end else if (write_en) begin
      dout <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an array model of the memory.
module tb_prog_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              resetn;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              write_en;
  logic [DATA_W-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  prog_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .addr     (addr),
    .din      (din),
    .write_en (write_en),
    .dout     (dout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain array plus the value the output register must hold.
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] model_dout;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_dout = '0;
    end else if (int'(addr) >= DEPTH) begin
      model_dout = '0;
    end else begin
      if (write_en) model_mem[addr] = din;
      model_dout = model_mem[addr];
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) check("dout_vs_model", dout, model_dout);
  end

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic we);
    addr     = a;
    din      = d;
    write_en = we;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    addr     = '0;
    din      = '0;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    check("reset_dout", dout, 16'h0000);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Every word reads back the all-NOP image
    for (int a = 0; a < DEPTH; a++) begin
      cycle(ADDR_W'(a), 16'h0000, 1'b0);
      check($sformatf("reset_image_%0d", a), dout, 16'h0000);
    end

    // Write and readback
    cycle(4'd3, 16'hA5C3, 1'b1);
    cycle(4'd15, 16'h1234, 1'b1);
    cycle(4'd3, 16'h0000, 1'b0);
    check("readback_3", dout, 16'hA5C3);
    cycle(4'd15, 16'h0000, 1'b0);
    check("readback_15", dout, 16'h1234);
    cycle(4'd4, 16'h0000, 1'b0);
    check("readback_4", dout, 16'h0000);

    // write_en low leaves memory untouched
    for (int k = 0; k < 3; k++) begin
      cycle(4'd3, 16'hFFFF, 1'b0);
      check("no_write_3", dout, 16'hA5C3);
    end

    // Write-first collision
    cycle(4'd7, 16'h1111, 1'b1);
    check("collision_first", dout, 16'h1111);
    cycle(4'd7, 16'hBEEF, 1'b1);
    check("collision_beef", dout, 16'hBEEF);
    cycle(4'd7, 16'h0000, 1'b0);
    check("collision_hold", dout, 16'hBEEF);

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 400; k++) begin
      cycle(ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom),
            ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset mid-cycle
    cycle(4'd3, 16'hA5C3, 1'b1);
    cycle(4'd3, 16'h0000, 1'b0);
    check("pre_async_reset", dout, 16'hA5C3);
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_dout", dout, 16'h0000);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    cycle(4'd3, 16'h0000, 1'b0);
    check("after_reset_3", dout, 16'h0000);
    cycle(4'd7, 16'h0000, 1'b0);
    check("after_reset_7", dout, 16'h0000);

    // Writes during reset are ignored
    resetn   = 1'b0;
    write_en = 1'b1;
    addr     = 4'd5;
    din      = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    check("reset_write_dout", dout, 16'h0000);
    @(posedge clk);
    #2;
    resetn   = 1'b1;
    write_en = 1'b0;
    cycle(4'd5, 16'h0000, 1'b0);
    check("reset_write_5", dout, 16'h0000);

    repeat (2) @(posedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Small single-port program memory for the QUAD.nibble CPU: DEPTH words of DATA_W bits, addressed by a 4-bit address.
- Synchronous write and registered (one-cycle) read.
- Contents are loaded from a reset image while reset is asserted.
- Sits beside the CPU core, which uses it for instruction fetch and program loading.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- addr  input  ADDR_W  word address for both read and write.
- din  input  DATA_W  write data.
- write_en  input  1  active-high write strobe, sampled at rising clk.
- dout  output  DATA_W  registered read data.

Behaviour:
- Reset (resetn=0, asynchronous):
  - dout clears to 0 immediately.
  - mem[i] is loaded with PROGMEM_RESET_IMAGE[i] for every i.
  - Held while resetn=0; writes are ignored during reset.
- Reset release is synchronised by the environment; the first active edge after resetn rises performs a normal read/write.
- Write: at rising clk with resetn=1 and write_en=1 and addr<DEPTH, mem[addr] <= din.
- Read:
  - At every rising clk with resetn=1, dout <= mem[addr].
  - Latency is 1 cycle: address presented in cycle N appears on dout after edge N.
- Read-during-write (same edge, write_en=1): write-first; dout <= din, so new data is visible one cycle later.
- Out of range (addr≥DEPTH, only possible when DEPTH<2**ADDR_W):
  - Write is ignored.
  - dout <= 0.
- write_en=0: memory unchanged; dout continues to track mem[addr] with 1-cycle latency.
- Reset mid-operation: any pending write on the same edge as reset assertion is discarded; the memory returns to the reset image.
- No X propagation: every array word and dout have defined values after reset.
- Storage: flop array (DEPTH×DATA_W), not inferred RAM, so that async reset-to-image is supported.

Decomposition:
- Shared package quad_nibble_pkg holds:
  - word_t (16-bit)
  - paddr_t (4-bit)
  - PROGMEM_DEPTH = 16
  - PROGMEM_RESET_IMAGE: array of 16 word_t, default all 16'h0000 (NOP).
- No sub-module; a single flat module with one array always_ff and one dout always_ff.

Test Plan:
1. Reset: hold resetn=0 for 1 cycle, then release 2 ns after rising clk; read addr 0..15 → dout=16'h0000 for each, one cycle after each address.
2. Write/readback: write addr 3 ← 16'hA5C3 and addr 15 ← 16'h1234 (write_en=1 one cycle each); then read addr 3 → 16'hA5C3 and addr 15 → 16'h1234 one cycle later; addr 4 → 16'h0000.
3. Write-first collision: write addr 7 ← 16'hBEEF with addr held at 7 → dout=16'hBEEF after that same edge; previous content is never shown.
4. write_en=0: drive din=16'hFFFF, addr 3, write_en=0 for 3 cycles → mem[3] stays 16'hA5C3; dout=16'hA5C3.
5. Async reset mid-run: after scenario 2, assert resetn=0 mid-cycle → dout=0 immediately without a clock edge; after release, addr 3 reads 16'h0000.
6. Write during reset: resetn=0, write_en=1, addr 5, din 16'h5555 over 2 edges; release → addr 5 reads 16'h0000.
